cache_ctrl_fsm: RTL and testbench

Direct-mapped, write-back, write-allocate cache controller between the RV32I core's load/store path and main memory. Holds 512 one-word lines, with tag and data arrays internal. Sequenced by a four-state FSM (IDLE, COMPARE_TAG, WRITE_BACK, ALLOCATE). Uses the `cache_def` types on both the CPU and memory sides.

---
 rtl/cache_ctrl_fsm.sv | 233 +++++++++++++++++++++++
 tb/tb_cache_ctrl_fsm.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_fsm.sv
// cache_ctrl_fsm: direct-mapped, write-back, write-allocate cache with 512 one-word lines.
// Define CACHE_PERF_CNT_EN to enable the hit_cnt/miss_cnt counters (tied to 0 otherwise).

package cache_def;
  localparam int unsigned TAGMSB = 31;
  localparam int unsigned TAGLSB = 11;
  localparam int unsigned LINES  = 512;

  typedef struct packed {
    logic                valid;
    logic                dirty;
    logic [TAGMSB:TAGLSB] tag;
  } cache_tag_type;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
    logic        valid;
  } cpu_req_type;

  typedef struct packed {
    logic [31:0] data;
    logic        ready;
  } cpu_result_type;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
    logic        valid;
  } mem_req_type;

  typedef struct packed {
    logic [31:0] data;
    logic        ready;
  } mem_data_type;
endpackage

module cache_ctrl_fsm
  import cache_def::*;
(
  input  logic           clk,
  input  logic           rst,
  input  cpu_req_type    cpu_req,
  input  mem_data_type   mem_data,
  output cpu_result_type cpu_res,
  output mem_req_type    mem_req,
  output logic [31:0]    hit_cnt,
  output logic [31:0]    miss_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    COMPARE_TAG,
    WRITE_BACK,
    ALLOCATE
  } state_t;

  state_t               state_q, state_d;
  logic [31:2]          req_addr_q, req_addr_d;
  logic [31:0]          req_data_q, req_data_d;
  logic                 req_rw_q, req_rw_d;
  logic [TAGMSB:TAGLSB] wb_tag_q, wb_tag_d;

  cache_tag_type tag_q  [LINES];
  logic [31:0]   data_q [LINES];

  logic [8:0]    idx;
  cache_tag_type cur_tag;
  logic          hit;
  logic          tag_we;
  cache_tag_type tag_wval;
  logic          data_we;
  logic [31:0]   data_wval;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cpu_req.addr[1:0];

  assign idx     = req_addr_q[10:2];
  assign cur_tag = tag_q[idx];
  assign hit     = cur_tag.valid && (cur_tag.tag == req_addr_q[31:11]);

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    req_rw_d   = req_rw_q;
    wb_tag_d   = wb_tag_q;
    tag_we     = 1'b0;
    tag_wval   = cur_tag;
    data_we    = 1'b0;
    data_wval  = req_data_q;
    case (state_q)
      IDLE: begin
        if (cpu_req.valid) begin
          req_addr_d = cpu_req.addr[31:2];
          req_data_d = cpu_req.data;
          req_rw_d   = cpu_req.rw;
          state_d    = COMPARE_TAG;
        end
      end
      COMPARE_TAG: begin
        if (hit) begin
          if (req_rw_q) begin
            data_we        = 1'b1;
            data_wval      = req_data_q;
            tag_we         = 1'b1;
            tag_wval.dirty = 1'b1;
          end
          state_d = IDLE;
        end else begin
          // New tag is installed now; the evicted tag survives in wb_tag_q for the write-back.
          tag_we   = 1'b1;
          tag_wval = cache_tag_type'{valid: 1'b1, dirty: req_rw_q, tag: req_addr_q[31:11]};
          wb_tag_d = cur_tag.tag;
          state_d  = (cur_tag.valid && cur_tag.dirty) ? WRITE_BACK : ALLOCATE;
        end
      end
      WRITE_BACK: begin
        if (mem_data.ready) begin
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (mem_data.ready) begin
          data_we   = 1'b1;
          data_wval = mem_data.data;
          state_d   = COMPARE_TAG;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_res = '0;
    mem_req = '0;
    case (state_q)
      COMPARE_TAG: begin
        if (hit) begin
          cpu_res.ready = 1'b1;
          if (!req_rw_q) begin
            cpu_res.data = data_q[idx];
          end
        end
      end
      WRITE_BACK: begin
        mem_req.addr  = {wb_tag_q, idx, 2'b00};
        mem_req.data  = data_q[idx];
        mem_req.rw    = 1'b1;
        mem_req.valid = 1'b1;
      end
      ALLOCATE: begin
        mem_req.addr  = {req_addr_q, 2'b00};
        mem_req.rw    = 1'b0;
        mem_req.valid = 1'b1;
      end
      default: begin
        cpu_res = '0;
        mem_req = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_rw_q   <= 1'b0;
      wb_tag_q   <= '0;
      for (int unsigned i = 0; i < LINES; i++) begin
        tag_q[i].valid <= 1'b0;
        tag_q[i].dirty <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      req_rw_q   <= req_rw_d;
      wb_tag_q   <= wb_tag_d;
      if (tag_we) begin
        tag_q[idx] <= tag_wval;
      end
    end
  end

  // Data array has no reset; reset only blocks an in-flight write.
  always_ff @(posedge clk) begin
    if (!rst && data_we) begin
      data_q[idx] <= data_wval;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic        from_alloc_q;

  // COMPARE_TAG is entered only from IDLE or ALLOCATE, so this marks the refill re-compare.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == COMPARE_TAG) begin
      if (!hit) begin
        miss_cnt_d = miss_cnt_q + 32'd1;
      end else if (!from_alloc_q) begin
        hit_cnt_d = hit_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      from_alloc_q <= 1'b0;
    end else begin
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      from_alloc_q <= (state_q == ALLOCATE);
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// tb_cache_ctrl_fsm: directed cache scenarios followed by random accesses, checked against
// a word-level architectural memory model plus a tag-only model of the direct-mapped cache.

module tb_cache_ctrl_fsm;
  import cache_def::*;

  logic           clk = 1'b0;
  logic           rst;
  cpu_req_type    cpu_req;
  mem_data_type   mem_data;
  cpu_result_type cpu_res;
  mem_req_type    mem_req;
  logic [31:0]    hit_cnt;
  logic [31:0]    miss_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  cache_ctrl_fsm dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .mem_data (mem_data),
    .cpu_res  (cpu_res),
    .mem_req  (mem_req),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  logic [31:0] memv [logic [31:0]];   // backing memory contents
  logic [31:0] gold [logic [31:0]];   // value the CPU must observe
  logic        m_valid [512];
  logic        m_dirty [512];
  logic [20:0] m_tag   [512];
  int unsigned exp_hit;
  int unsigned exp_miss;

  logic [31:0] r_data;
  int unsigned r_lat;

  task automatic chk(input string name, input logic [65:0] obs, input logic [65:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [31:0] mem_get(input logic [31:0] a);
    return memv.exists(a) ? memv[a] : init_word(a);
  endfunction

  function automatic logic [31:0] gold_get(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : init_word(a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 512; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
    gold     = memv;   // dirty data still in the cache is lost
    exp_hit  = 0;
    exp_miss = 0;
  endtask

  // Entered and left just after a falling edge.
  task automatic access(input logic [31:0] addr, input logic [31:0] wdata, input logic rw,
                        input int unsigned lat_r, input int unsigned lat_w);
    logic [31:0] a;
    logic [8:0]  idx;
    logic [20:0] tg;
    logic        hit, evict, done, stable, quiet, prev_valid, prev_ready;
    logic [31:0] ev_addr, ev_data, exp_rd;
    int unsigned exp_lat, exp_nreq, nreq, cnt, c;
    mem_req_type first, cur;

    a       = {addr[31:2], 2'b00};
    idx     = addr[10:2];
    tg      = addr[31:11];
    hit     = m_valid[idx] && (m_tag[idx] == tg);
    evict   = !hit && m_valid[idx] && m_dirty[idx];
    ev_addr = {m_tag[idx], idx, 2'b00};
    ev_data = gold_get(ev_addr);
    exp_rd  = rw ? 32'h0 : gold_get(a);
    exp_lat = hit ? 1 : (evict ? lat_w + lat_r + 2 : lat_r + 2);
    exp_nreq = hit ? 0 : (evict ? 2 : 1);
    if (hit) begin
      if (rw) m_dirty[idx] = 1'b1;
`ifdef CACHE_PERF_CNT_EN
      exp_hit++;
`endif
    end else begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_dirty[idx] = rw;
`ifdef CACHE_PERF_CNT_EN
      exp_miss++;
`endif
    end
    if (rw) gold[a] = wdata;

    cpu_req = '{addr: addr, data: wdata, rw: rw, valid: 1'b1};
    nreq = 0; cnt = 0; c = 0; done = 1'b0; stable = 1'b1; quiet = 1'b1;
    prev_valid = 1'b0; prev_ready = 1'b0; first = '0;
    r_lat = 0; r_data = '0;
    while (!done && c < 60) begin
      @(posedge clk);
      @(negedge clk);
      c++;
      cur = mem_req;
      if (cur.valid) begin
        if (!prev_valid || prev_ready) begin
          nreq++;
          cnt   = 1;
          first = cur;
          if (evict && nreq == 1) begin
            chk("wb_addr", cur.addr, ev_addr);
            chk("wb_data", cur.data, ev_data);
            chk("wb_rw", cur.rw, 1'b1);
          end else begin
            chk("alloc_addr", cur.addr, a);
            chk("alloc_rw", cur.rw, 1'b0);
          end
        end else begin
          cnt++;
          if (cur !== first) stable = 1'b0;
        end
        if (cur.rw) begin
          mem_data.ready = (cnt >= lat_w);
          mem_data.data  = $urandom;
          if (mem_data.ready) memv[cur.addr] = cur.data;
        end else begin
          mem_data.ready = (cnt >= lat_r);
          mem_data.data  = mem_data.ready ? mem_get(cur.addr) : $urandom;
        end
      end else begin
        mem_data.ready = 1'($urandom_range(0, 1));
        mem_data.data  = $urandom;
      end
      prev_valid = cur.valid;
      prev_ready = cur.valid && mem_data.ready;
      if (cpu_res.ready) begin
        done   = 1'b1;
        r_lat  = c;
        r_data = cpu_res.data;
      end else if (cpu_res.data !== 32'h0) begin
        quiet = 1'b0;
      end
    end
    cpu_req.valid = 1'b0;
    chk("resp_seen", done, 1'b1);
    chk("latency", r_lat, exp_lat);
    chk("rd_data", r_data, exp_rd);
    chk("mem_req_count", nreq, exp_nreq);
    chk("mem_req_stable", stable, 1'b1);
    chk("data_zero_not_ready", quiet, 1'b1);
    @(posedge clk);
    @(negedge clk);
    mem_data.ready = 1'($urandom_range(0, 1));
    chk("ready_pulse", cpu_res.ready, 1'b0);
    chk("idle_mem_valid", mem_req.valid, 1'b0);
    chk("hit_cnt", hit_cnt, exp_hit);
    chk("miss_cnt", miss_cnt, exp_miss);
  endtask

  initial begin
    logic [31:0] ra;
    logic [8:0]  rix;
    logic [20:0] rtg;

    rst      = 1'b1;
    cpu_req  = '0;
    mem_data = '0;
    memv[32'h0000_0100] = 32'hDEAD_BEEF;
    memv[32'h0000_0900] = 32'hCAFE_F00D;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_cpu_res", cpu_res, 66'h0);
    chk("reset_mem_req", mem_req, 66'h0);
    chk("reset_hit_cnt", hit_cnt, 66'h0);
    chk("reset_miss_cnt", miss_cnt, 66'h0);
    rst = 1'b0;

    // Cold read, then repeat-read hit.
    access(32'h0000_0100, 32'h0, 1'b0, 3, 1);
    chk("cold_rd_data", r_data, 32'hDEAD_BEEF);
    chk("cold_rd_lat", r_lat, 5);
    access(32'h0000_0100, 32'h0, 1'b0, 2, 1);
    chk("hit_rd_data", r_data, 32'hDEAD_BEEF);
    chk("hit_rd_lat", r_lat, 1);

    // Dirty the line, then evict it with a conflicting read.
    access(32'h0000_0100, 32'h1234_5678, 1'b1, 2, 1);
    access(32'h0000_0900, 32'h0, 1'b0, 2, 2);
    chk("conflict_rd_data", r_data, 32'hCAFE_F00D);
    chk("conflict_rd_lat", r_lat, 6);
    chk("wb_mem_0x100", mem_get(32'h0000_0100), 32'h1234_5678);

    // Write miss on a clean entry, later evicted by a conflicting read.
    access(32'h0000_0204, 32'hABCD_0001, 1'b1, 1, 1);
    chk("wr_miss_lat", r_lat, 3);
    access(32'h0000_0A04, 32'h0, 1'b0, 1, 3);
    chk("wb_mem_0x204", mem_get(32'h0000_0204), 32'hABCD_0001);
    chk("evict_rd_lat", r_lat, 6);

    // Reset while ALLOCATE waits; the ready offered at the reset edge must be dropped.
    cpu_req  = '{addr: 32'h0000_1300, data: 32'h0, rw: 1'b0, valid: 1'b1};
    mem_data = '0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("rst_alloc_valid", mem_req.valid, 1'b1);
    chk("rst_alloc_addr", mem_req.addr, 32'h0000_1300);
    rst           = 1'b1;
    cpu_req.valid = 1'b0;
    mem_data      = '{data: 32'h0BAD_0BAD, ready: 1'b1};
    @(posedge clk); @(negedge clk);
    rst      = 1'b0;
    mem_data = '0;
    chk("rst_abort_mem_valid", mem_req.valid, 1'b0);
    chk("rst_abort_cpu_ready", cpu_res.ready, 1'b0);
    chk("rst_abort_hit_cnt", hit_cnt, 32'h0);
    chk("rst_abort_miss_cnt", miss_cnt, 32'h0);
    model_reset();
    @(posedge clk); @(negedge clk);
    chk("rst_idle_mem_valid", mem_req.valid, 1'b0);
    access(32'h0000_1300, 32'h0, 1'b0, 2, 1);
    chk("rst_reread_lat", r_lat, 4);
    access(32'h0000_0100, 32'h0, 1'b0, 1, 1);
    chk("rst_lost_line_lat", r_lat, 3);

    // Random traffic concentrated on a few indices to force conflicts and evictions.
    for (int n = 0; n < 250; n++) begin
      rtg = 21'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) rix = 9'($urandom);
      else                           rix = 9'(9'h040 + 9'($urandom_range(0, 2)));
      ra = {rtg, rix, 2'($urandom)};
      access(ra, $urandom, 1'($urandom_range(0, 1)), $urandom_range(1, 4), $urandom_range(1, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
